// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Front-end controller for the 8-bit ALU datapath. Collects operand A,
// operand B and the opcode from a shared switch bus, one button press per
// item in fixed order. It then drives them to the ALU, waits a fixed ALU
// latency, and captures and holds the result for display.

module alu_operand_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int OP_WIDTH    = 6,
    parameter int ALU_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sw,
    input  logic                  btn_a,
    input  logic                  btn_b,
    input  logic                  btn_op,
    input  logic [DATA_WIDTH-1:0] alu_z,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_o
);

    // State encodings are exported on state_o for the debug LEDs
    localparam logic [2:0] LOAD_A  = 3'd0;
    localparam logic [2:0] LOAD_B  = 3'd1;
    localparam logic [2:0] LOAD_OP = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] SHOW    = 3'd4;

    // Four bits cover the full 1..15 latency range
    localparam int               CNT_W      = 4;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ALU_LATENCY - 1);

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_aluA;
    logic [DATA_WIDTH-1:0] r_aluB;
    logic [OP_WIDTH-1:0]   r_aluOp;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_done;
    logic                  r_btnAPrev;
    logic                  r_btnBPrev;
    logic                  r_btnOpPrev;

    logic                  w_pressA;
    logic                  w_pressB;
    logic                  w_pressOp;
    logic                  w_countDone;

    // A press is a rising edge, so holding a button produces a single event
    assign w_pressA    = btn_a  & ~r_btnAPrev;
    assign w_pressB    = btn_b  & ~r_btnBPrev;
    assign w_pressOp   = btn_op & ~r_btnOpPrev;
    assign w_countDone = (r_count == LAST_COUNT);

    // Track previous button levels; reset to 1 so a button held through reset needs a fresh press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btnAPrev  <= 1'b1;
            r_btnBPrev  <= 1'b1;
            r_btnOpPrev <= 1'b1;
        end else begin
            r_btnAPrev  <= btn_a;
            r_btnBPrev  <= btn_b;
            r_btnOpPrev <= btn_op;
        end
    end

    // Sequencer: load A, B and opcode in order, wait out the ALU latency, then capture and show
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= LOAD_A;
            r_count  <= '0;
            r_aluA   <= '0;
            r_aluB   <= '0;
            r_aluOp  <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD_A: begin
                    if (w_pressA) begin
                        r_aluA  <= sw;
                        r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_pressB) begin
                        r_aluB  <= sw;
                        r_state <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (w_pressOp) begin
                        r_aluOp <= sw[OP_WIDTH-1:0];
                        r_count <= '0;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (w_countDone) begin
                        r_result <= alu_z;
                        r_done   <= 1'b1;
                        r_state  <= SHOW;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                SHOW: begin
                    if (w_pressA) begin
                        r_aluA  <= sw;
                        r_state <= LOAD_B;
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

    assign alu_a   = r_aluA;
    assign alu_b   = r_aluB;
    assign alu_op  = r_aluOp;
    assign result  = r_result;
    assign done    = r_done;
    assign busy    = (r_state == EXEC);
    assign state_o = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer
// Runs two instances side by side: one with ALU latency 1 fed by an A&B
// ALU model, and one with ALU latency 3 fed by a bench-driven result.

module tb_alu_operand_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic       btnA;
    logic       btnB;
    logic       btnOp;

    logic [7:0] aluZ1;
    logic [7:0] aluA1;
    logic [7:0] aluB1;
    logic [5:0] aluOp1;
    logic [7:0] result1;
    logic       busy1;
    logic       done1;
    logic [2:0] state1;

    logic [7:0] aluZ3;
    logic [7:0] aluA3;
    logic [7:0] aluB3;
    logic [5:0] aluOp3;
    logic [7:0] result3;
    logic       busy3;
    logic       done3;
    logic [2:0] state3;

    int checks;
    int failures;
    int doneCount3;
    int doneSnap3;

    alu_operand_sequencer #(.DATA_WIDTH(8), .OP_WIDTH(6), .ALU_LATENCY(1)) u_dutLat1 (
        .clk(clk), .reset(reset), .sw(sw),
        .btn_a(btnA), .btn_b(btnB), .btn_op(btnOp),
        .alu_z(aluZ1), .alu_a(aluA1), .alu_b(aluB1), .alu_op(aluOp1),
        .result(result1), .busy(busy1), .done(done1), .state_o(state1)
    );

    alu_operand_sequencer #(.DATA_WIDTH(8), .OP_WIDTH(6), .ALU_LATENCY(3)) u_dutLat3 (
        .clk(clk), .reset(reset), .sw(sw),
        .btn_a(btnA), .btn_b(btnB), .btn_op(btnOp),
        .alu_z(aluZ3), .alu_a(aluA3), .alu_b(aluB3), .alu_op(aluOp3),
        .result(result3), .busy(busy3), .done(done3), .state_o(state3)
    );

    // Simple ALU model for the latency-1 instance: bitwise AND
    assign aluZ1 = aluA1 & aluB1;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count done pulses of the latency-3 instance so a stray pulse can be detected
    always @(negedge clk) begin
        if (done3 === 1'b1) doneCount3++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Press one button (0=A, 1=B, 2=OP) for one cycle with the given switch value
    task automatic applyStimulus(input int btnSel, input logic [7:0] value);
        @(negedge clk);
        sw = value;
        if (btnSel == 0) btnA = 1'b1;
        else if (btnSel == 1) btnB = 1'b1;
        else btnOp = 1'b1;
        @(negedge clk);
        btnA  = 1'b0;
        btnB  = 1'b0;
        btnOp = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        doneCount3 = 0;
        doneSnap3  = 0;
        reset      = 1'b1;
        sw         = 8'h00;
        btnA       = 1'b0;
        btnB       = 1'b0;
        btnOp      = 1'b0;
        aluZ3      = 8'h11;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_state",  state1,  3'd0);
        checkOutput("rst_alu_a",  aluA1,   8'h00);
        checkOutput("rst_alu_op", aluOp1,  6'h00);
        checkOutput("rst_result", result1, 8'h00);
        checkOutput("rst_busy",   busy1,   1'b0);
        checkOutput("rst_done",   done1,   1'b0);
        reset = 1'b0;

        // Out-of-order presses from LOAD_A are ignored
        applyStimulus(1, 8'h55);
        applyStimulus(2, 8'h55);
        checkOutput("ooo_state", state1, 3'd0);
        checkOutput("ooo_alu_b", aluB1,  8'h00);
        checkOutput("ooo_alu_op", aluOp1, 6'h00);
        checkOutput("ooo_alu_a", aluA1,  8'h00);

        // Held btn_a for 10 cycles gives exactly one load
        @(negedge clk);
        sw   = 8'hF0;
        btnA = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("hold_state", state1, 3'd1);
        checkOutput("hold_alu_a", aluA1,  8'hF0);
        btnA = 1'b0;
        @(negedge clk);
        checkOutput("hold_state_after", state1, 3'd1);

        // Load B
        applyStimulus(1, 8'h3C);
        checkOutput("load_b_state", state1, 3'd2);
        checkOutput("load_b_value", aluB1,  8'h3C);

        // Load opcode; both instances enter EXEC
        applyStimulus(2, 8'h24);
        checkOutput("exec1_op",    aluOp1, 6'h24);
        checkOutput("exec1_busy",  busy1,  1'b1);
        checkOutput("exec1_state", state1, 3'd3);
        checkOutput("exec1_done",  done1,  1'b0);
        checkOutput("exec3_busy_c1", busy3, 1'b1);
        btnB = 1'b1;
        sw   = 8'h77;

        // One cycle later: latency-1 capture, latency-3 still busy; A&B = 0x30
        @(negedge clk);
        checkOutput("lat1_result", result1, 8'h30);
        checkOutput("lat1_done",   done1,   1'b1);
        checkOutput("lat1_busy",   busy1,   1'b0);
        checkOutput("lat1_state",  state1,  3'd4);
        checkOutput("exec3_busy_c2", busy3,  1'b1);
        checkOutput("exec3_done_c2", done3,  1'b0);
        checkOutput("exec3_result_c2", result3, 8'h00);
        aluZ3 = 8'h30;
        btnB  = 1'b0;
        btnOp = 1'b1;

        @(negedge clk);
        checkOutput("lat1_done_width", done1,   1'b0);
        checkOutput("lat1_result_hold", result1, 8'h30);
        checkOutput("exec3_busy_c3", busy3,  1'b1);
        checkOutput("exec3_alu_b",   aluB3,  8'h3C);
        checkOutput("exec3_alu_op",  aluOp3, 6'h24);
        btnOp = 1'b0;

        @(negedge clk);
        checkOutput("lat3_result", result3, 8'h30);
        checkOutput("lat3_done",   done3,   1'b1);
        checkOutput("lat3_busy",   busy3,   1'b0);
        checkOutput("lat3_state",  state3,  3'd4);
        checkOutput("lat3_alu_a",  aluA3,   8'hF0);

        @(negedge clk);
        checkOutput("lat3_done_width", done3, 1'b0);

        // Re-run from SHOW
        applyStimulus(0, 8'hAA);
        checkOutput("rerun_alu_a",  aluA1,   8'hAA);
        checkOutput("rerun_state",  state1,  3'd1);
        checkOutput("rerun_result", result1, 8'h30);
        checkOutput("rerun_alu_b",  aluB1,   8'h3C);
        checkOutput("rerun3_result", result3, 8'h30);

        // Reset mid-EXEC on the latency-3 instance
        applyStimulus(1, 8'h0F);
        aluZ3 = 8'h11;
        applyStimulus(2, 8'h01);
        checkOutput("abort_busy", busy3, 1'b1);
        doneSnap3 = doneCount3;
        @(negedge clk);
        checkOutput("rerun_lat1_result", result1, 8'h0A);
        checkOutput("abort_pre_busy", busy3, 1'b1);
        btnA  = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("abort_state",  state3,  3'd0);
        checkOutput("abort_alu_a",  aluA3,   8'h00);
        checkOutput("abort_alu_b",  aluB3,   8'h00);
        checkOutput("abort_alu_op", aluOp3,  6'h00);
        checkOutput("abort_result", result3, 8'h00);
        checkOutput("abort_busy0",  busy3,   1'b0);
        checkOutput("abort_done",   done3,   1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("held_state", state3, 3'd0);
        checkOutput("held_alu_a", aluA3,  8'h00);
        checkOutput("abort_no_done", doneCount3, doneSnap3);
        btnA = 1'b0;

        // Fresh press after release loads A
        applyStimulus(0, 8'h5A);
        checkOutput("post_alu_a", aluA3,  8'h5A);
        checkOutput("post_state", state3, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Front-end controller for the 8-bit ALU datapath (AND/OR/ADD/... units selected by opcode).
- Collects operand A, operand B and opcode from a shared switch bus, one per button press, in fixed order.
- Drives them to the ALU, waits a fixed ALU latency, captures the result and holds it for display.
- Sits between the board I/O (debounced switches/buttons) and the ALU top.

Parameters:
- DATA_WIDTH, 8, width of operands, switch bus and result.
- OP_WIDTH, 6, width of the opcode field (low OP_WIDTH bits of sw).
- ALU_LATENCY, 1, clock cycles from stable ALU inputs to valid alu_z; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw  input  DATA_WIDTH  shared switch bus (operand or opcode value).
- btn_a  input  1  debounced level; a rising edge loads A.
- btn_b  input  1  debounced level; a rising edge loads B.
- btn_op  input  1  debounced level; a rising edge loads the opcode.
- alu_z  input  DATA_WIDTH  ALU result.
- alu_a  output  DATA_WIDTH  registered operand A to the ALU.
- alu_b  output  DATA_WIDTH  registered operand B to the ALU.
- alu_op  output  OP_WIDTH  registered opcode to the ALU.
- result  output  DATA_WIDTH  captured ALU result, held until the next capture.
- busy  output  1  high while in EXEC.
- done  output  1  one-cycle pulse on the cycle result updates.
- state_o  output  3  current state encoding, for LED debug.

Behaviour:
- Reset (async, immediate): alu_a=0, alu_b=0, alu_op=0, result=0, busy=0, done=0, latency counter=0, state=LOAD_A (state_o=0).
- Edge-detect registers reset to 1, so a button held through reset release does not fire until released and pressed again.
- Edge detect: press = btn & ~btn_prev, with btn_prev registered every cycle. One press equals one event regardless of hold length.
- States and encodings:
  - LOAD_A=0: on press_a, alu_a<=sw, go LOAD_B.
  - LOAD_B=1: on press_b, alu_b<=sw, go LOAD_OP.
  - LOAD_OP=2: on press_op, alu_op<=sw[OP_WIDTH-1:0], counter<=0, go EXEC.
  - EXEC=3: busy=1; counter increments each cycle. When counter==ALU_LATENCY-1: result<=alu_z, done<=1 for the next cycle only, go SHOW.
  - SHOW=4: result held. On press_a, alu_a<=sw, go LOAD_B (new sequence). press_b and press_op are ignored.
- Out-of-order presses (a button not expected in the current state) are ignored: no register change, no state change.
- All presses are ignored in EXEC.
- Simultaneous presses: only the press expected by the current state takes effect; the others are dropped, not queued.
- Latency: result is valid ALU_LATENCY cycles after the cycle in which alu_op updates. done rises on the same edge result updates.
- alu_a, alu_b and alu_op keep their values through EXEC and SHOW and change only on their own load event.
- Reset asserted mid-EXEC aborts the operation: all outputs return to reset values at once and no done pulse is produced.
- Unused state encodings 5..7 recover to LOAD_A on the next clock.
- No arithmetic is performed in this block. Widths pass through unchanged; alu_op takes the low bits of sw.

Test Plan:
- Reset then sequence: sw=0xF0 with btn_a edge, sw=0x3C with btn_b edge, sw=0x24 with btn_op edge; ALU model Z=A&B, ALU_LATENCY=1 -> alu_a=0xF0, alu_b=0x3C, alu_op=0x24, busy high for 1 cycle, result=0x30, done high exactly 1 cycle, state_o=4.
- Out of order: from LOAD_A, pulse btn_b then btn_op with sw=0x55 -> no register changes, state_o stays 0; a following btn_a edge loads A.
- Held button: hold btn_a high for 10 cycles, then release -> exactly one load, state advances only to LOAD_B.
- ALU_LATENCY=3, alu_z model changes from 0x11 to 0x30 one cycle after alu_op updates -> result=0x30 captured on the 3rd EXEC cycle; busy high for 3 cycles; presses during EXEC ignored.
- Reset mid-EXEC (ALU_LATENCY=3, assert reset during the 2nd EXEC cycle) -> immediate zeros on all outputs, no done pulse, state_o=0; btn_a held across reset does not load.
- Re-run from SHOW: btn_a edge with sw=0xAA -> alu_a=0xAA, state_o=1, result still shows the previous value until the next capture.
